// File: rtl/cordic_ln_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_ln_sched                                            |
// | Description : Round-robin scheduler sharing one cordic_In ln pipeline    |
// |               among N requesters, with tag-based result routing.         |
// |               Optional operand range check under RANGE_CHECK_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cordic_ln_sched #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int PIPELINE = 16,
    parameter int OUTST    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_vaild,
    input  logic [32*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic [31:0]       cor_iData,
    output logic              cor_pre_vaild,
    input  logic [31:0]       cor_In,
    input  logic              cor_post_vaild,
    output logic              rsp_vaild,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              seq_err,
    output logic              busy
);

    localparam int              c_lat   = PIPELINE + 2;
    localparam int              c_cw    = $clog2(OUTST + 1);
    localparam logic [c_cw-1:0] c_outst = c_cw'(OUTST);

    logic [IDW-1:0]  r_ptr;
    logic [c_cw-1:0] r_cnt [N];
    logic [N-1:0]    w_elig;
    logic [N-1:0]    w_grant;
    logic [N-1:0]    w_dec;
    logic [N-1:0]    w_nz;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_hs;
    int              w_idx;
    logic [31:0]     w_op;
    logic            w_rng_err;
    logic            w_tail_err;

    logic            r_iss_v;
    logic [IDW-1:0]  r_iss_id;
    logic            r_tv  [c_lat];
    logic [IDW-1:0]  r_tid [c_lat];
    logic            w_tail_v;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign w_elig[gi] = req_vaild[gi] & (r_cnt[gi] < c_outst);
        assign w_dec[gi]  = rsp_vaild & (rsp_id == IDW'(gi));
        assign w_nz[gi]   = |r_cnt[gi];
    end

    // First eligible requester at or after the pointer, wrapping N-1 -> 0.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_hs     = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_hs && w_elig[w_idx]) begin
                w_hs            = 1'b1;
                w_gnt_id        = IDW'(w_idx);
                w_grant[w_idx]  = 1'b1;
            end
        end
        if (!rst_n) begin
            w_grant = '0;
            w_hs    = 1'b0;
        end
    end

    assign req_ready = w_grant;
    assign w_op      = req_data[int'(w_gnt_id)*32 +: 32];
    assign w_tail_v  = r_tv[c_lat-1];
    assign busy      = |w_nz;

`ifdef RANGE_CHECK_EN
    logic r_iss_err;
    logic r_terr [c_lat];

    assign w_rng_err  = ($signed(w_op) < 32'sd6554) || ($signed(w_op) > 32'sd627835);
    assign w_tail_err = r_terr[c_lat-1];

    // Rejected operands still occupy a tag slot so their response keeps normal latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_err <= 1'b0;
            rsp_err   <= 1'b0;
            for (int k = 0; k < c_lat; k++) r_terr[k] <= 1'b0;
        end else begin
            r_iss_err <= w_hs & w_rng_err;
            r_terr[0] <= r_iss_err;
            for (int k = 1; k < c_lat; k++) r_terr[k] <= r_terr[k-1];
            rsp_err   <= r_terr[c_lat-1];
        end
    end
`else
    assign w_rng_err  = 1'b0;
    assign w_tail_err = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            cor_pre_vaild <= 1'b0;
            cor_iData     <= '0;
            r_iss_v       <= 1'b0;
            r_iss_id      <= '0;
            rsp_vaild     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            seq_err       <= 1'b0;
            for (int k = 0; k < c_lat; k++) begin
                r_tv[k]  <= 1'b0;
                r_tid[k] <= '0;
            end
        end else begin
            r_iss_v       <= w_hs;
            cor_pre_vaild <= w_hs & ~w_rng_err;
            if (w_hs) begin
                r_ptr    <= (w_gnt_id == IDW'(N-1)) ? '0 : w_gnt_id + IDW'(1);
                r_iss_id <= w_gnt_id;
            end
            if (w_hs && !w_rng_err) cor_iData <= w_op;

            r_tv[0]  <= r_iss_v;
            r_tid[0] <= r_iss_id;
            for (int k = 1; k < c_lat; k++) begin
                r_tv[k]  <= r_tv[k-1];
                r_tid[k] <= r_tid[k-1];
            end

            rsp_vaild <= w_tail_v;
            rsp_id    <= r_tid[c_lat-1];
            rsp_data  <= w_tail_err ? 32'd0 : cor_In;
            if (cor_post_vaild != (w_tail_v & ~w_tail_err)) seq_err <= 1'b1;
        end
    end

    // A grant and a response for the same requester in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_grant[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + c_cw'(1);
                else if (!w_grant[i] && w_dec[i] && w_nz[i])
                    r_cnt[i] <= r_cnt[i] - c_cw'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_ln_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cordic_ln_sched                                         |
// | Description : Scoreboard bench for cordic_ln_sched with a cordic_In      |
// |               behavioural model (fixed latency, ln lookup table).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cordic_ln_sched;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int PIPELINE = 16;
    localparam int OUTST    = 2;
    localparam int LAT      = PIPELINE + 2;
    localparam int RSP_LAT  = PIPELINE + 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_vaild = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     cor_iData;
    logic            cor_pre_vaild;
    logic [31:0]     cor_In;
    logic            cor_post_vaild;
    logic            rsp_vaild;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            seq_err;
    logic            busy;

    always #5 clk = ~clk;

    cordic_ln_sched #(.N(N), .IDW(IDW), .PIPELINE(PIPELINE), .OUTST(OUTST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vaild(req_vaild), .req_data(req_data), .req_ready(req_ready),
        .cor_iData(cor_iData), .cor_pre_vaild(cor_pre_vaild),
        .cor_In(cor_In), .cor_post_vaild(cor_post_vaild),
        .rsp_vaild(rsp_vaild), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .seq_err(seq_err), .busy(busy)
    );

    // cordic_In model: fixed LAT-cycle pipeline, not reset by the scheduler
    function automatic logic [31:0] ln_ref(input logic [31:0] x);
        case (x)
            32'd32768:  return 32'(-45426);
            32'd65536:  return 32'd0;
            32'd131072: return 32'd45426;
            32'd196608: return 32'd71999;
            32'd262144: return 32'd90852;
            32'd6554:   return 32'(-150898);
            32'd627835: return 32'd148090;
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [LAT-1:0] m_v = '0;
    logic [31:0]    m_res [LAT];
    logic           inject = 1'b0;

    always @(posedge clk) begin
        m_v      <= {m_v[LAT-2:0], cor_pre_vaild};
        m_res[0] <= ln_ref(cor_iData);
        for (int k = 1; k < LAT; k++) m_res[k] <= m_res[k-1];
    end

    assign cor_post_vaild = m_v[LAT-1] | inject;
    assign cor_In         = m_res[LAT-1];

    typedef struct { int id; logic [31:0] op; int exp; bit err; } op_t;
    typedef struct { int id; int exp; bit err; int cyc; } sb_t;
    typedef struct { int id; int cyc; } gl_t;

    op_t pend [$];
    sb_t sb   [$];
    gl_t glog [$];
    sb_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int req, input int tol);
        total++;
        if (act < req - tol || act > req + tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +/-%0d (cycle %0d)", nm, act, req, tol, cyc);
        end
    endtask

    task automatic add(input int id, input logic [31:0] op, input int exp, input bit err);
        pend.push_back('{id, op, exp, err});
    endtask

    // One cycle: present the oldest pending operand per requester, record the handshake.
    task automatic step();
        int pos [N];
        logic [N-1:0] v;
        @(negedge clk);
        v = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) pos[i] = -1;
        for (int j = pend.size() - 1; j >= 0; j--) pos[pend[j].id] = j;
        for (int i = 0; i < N; i++) begin
            if (pos[i] >= 0) begin
                v[i] = 1'b1;
                req_data[32*i +: 32] = pend[pos[i]].op;
            end
        end
        req_vaild = v;
        #1;
        if (req_ready != '0) begin
            chk("grant_onehot", $countones(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    if (pos[i] < 0) begin
                        chk("grant_without_valid", i, -1);
                    end else begin
                        sb.push_back('{i, pend[pos[i]].exp, pend[pos[i]].err, cyc + RSP_LAT});
                        glog.push_back('{i, cyc});
                        pend.delete(pos[i]);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        if (pend.size() != 0 || sb.size() != 0)
            chk("idle_timeout", pend.size() + sb.size(), 0);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_pre_vaild"}, cor_pre_vaild, 0);
        chk({tag, "_iData"}, cor_iData, 0);
        chk({tag, "_rsp_vaild"}, rsp_vaild, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: every response is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_vaild) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_err", rsp_err, mon_e.err);
                    chk("rsp_latency_cycle", cyc, mon_e.cyc);
                    chk_tol("rsp_data", int'($signed(rsp_data)), mon_e.exp, mon_e.err ? 0 : 4);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam int T2_ORDER [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    localparam int T3_OFS   [4] = '{0, 1, 21, 22};

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: single 0.5 operand from requester 0
        glog.delete();
        add(0, 32'd32768, -45426, 1'b0);
        step();
        step();
        chk("t1_busy_inflight", busy, 1);
        wait_idle(60);
        chk("t1_busy_idle", busy, 0);
        chk("t1_grants", glog.size(), 1);

        // T2: all requesters valid, round-robin from pointer 1
        glog.delete();
        add(0, 32'd65536, 0, 1'b0);      add(0, 32'd262144, 90852, 1'b0);
        add(1, 32'd131072, 45426, 1'b0); add(1, 32'd32768, -45426, 1'b0);
        add(2, 32'd196608, 71999, 1'b0); add(2, 32'd65536, 0, 1'b0);
        add(3, 32'd262144, 90852, 1'b0); add(3, 32'd131072, 45426, 1'b0);
        wait_idle(120);
        chk("t2_grants", glog.size(), 8);
        for (int j = 0; j < 8 && j < glog.size(); j++) begin
            chk("t2_order_id", glog[j].id, T2_ORDER[j]);
            chk("t2_order_cycle", glog[j].cyc - glog[0].cyc, j);
        end

        // T3: requester 2 alone, outstanding cap of 2
        glog.delete();
        add(2, 32'd32768, -45426, 1'b0);
        add(2, 32'd65536, 0, 1'b0);
        add(2, 32'd131072, 45426, 1'b0);
        add(2, 32'd196608, 71999, 1'b0);
        wait_idle(150);
        chk("t3_grants", glog.size(), 4);
        for (int j = 0; j < 4 && j < glog.size(); j++)
            chk("t3_grant_cycle", glog[j].cyc - glog[0].cyc, T3_OFS[j]);
        chk("t3_busy_idle", busy, 0);

        // T4: range check and boundaries
`ifdef RANGE_CHECK_EN
        add(1, 32'd0, 0, 1'b1);
        add(3, 32'd196608, 71999, 1'b0);
        add(0, 32'd6553, 0, 1'b1);
        add(1, 32'd6554, -150898, 1'b0);
        add(2, 32'd627835, 148090, 1'b0);
        add(3, 32'd627836, 0, 1'b1);
`else
        add(3, 32'd196608, 71999, 1'b0);
`endif
        wait_idle(120);
        chk("t4_seq_err", seq_err, 0);

        // T5: spurious post_vaild with empty tail
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (2) step();
        chk("t5_seq_err_set", seq_err, 1);
        repeat (10) step();
        chk("t5_seq_err_held", seq_err, 1);

        // T6: reset with five operations in flight
        add(0, 32'd65536, 0, 1'b0);
        add(1, 32'd131072, 45426, 1'b0);
        add(2, 32'd32768, -45426, 1'b0);
        add(3, 32'd196608, 71999, 1'b0);
        add(0, 32'd262144, 90852, 1'b0);
        repeat (5) step();
        chk("t6_inflight", sb.size(), 5);
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b0;
        req_vaild = '0;
        pend.delete();
        sb.delete();
        #1;
        chk_all_zero("t6_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add(2, 32'd131072, 45426, 1'b0);
        wait_idle(80);
        chk("t6_seq_err_stale", seq_err, 1);
        chk("t6_busy_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
